imm_gen_pipe: RTL and testbench
===============================

Name: imm_gen_pipe

Overview:
Parametrised, registered immediate generator for the decode stage. It accepts an instruction word and an immediate-format select over a valid/ready handshake. It produces the XLEN-wide extended immediate one cycle later, with a 1-entry skid buffer, flush and an illegal-select flag. It sits between the instruction fetch/decode register and the D-stage operand mux. It supports RV32 and RV64 shift-amount widths.

Parameters:
XLEN, 32, datapath width of the immediate; legal values are 32 and 64.
TAG_W, 5, width of the sideband tag (e.g. rd/ROB id) carried alongside each instruction.

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous kill of all held entries
in_valid  input  1  upstream entry valid
in_ready  output  1  block can accept an entry this cycle
in_inst  input  32  instruction word
in_sel  input  3  immediate format select
in_tag  input  TAG_W  sideband tag, passed through unchanged
out_valid  output  1  out_imm/out_tag/out_err valid
out_ready  input  1  downstream accepts
out_imm  output  XLEN  generated immediate
out_tag  output  TAG_W  tag of the output entry
out_err  output  1  in_sel was 3'd7 (no format); out_imm is 0

Behaviour:
- Reset is asynchronous (rst_n low): out_valid=0, skid valid=0, in_ready=1, out_imm=0, out_tag=0, out_err=0. Outputs stay stable while rst_n is low. Reset has priority over everything.
- sel encoding: 0=S, 1=B, 2=U, 3=J, 4=I, 5=I_star (shift amount), 6=CSR (zimm), 7=none.
- Formats. "sx" means sign-extend from inst[31] to XLEN.
  - S = sx{inst[31:25],inst[11:7]}.
  - B = sx{inst[31],inst[7],inst[30:25],inst[11:8],0}.
  - U = sx{inst[31:12],12'b0}. Sign-extended when XLEN=64.
  - J = sx{inst[31],inst[19:12],inst[20],inst[30:21],0}.
  - I = sx{inst[31:20]}.
  - I_star: zero-extended inst[24:20] when XLEN=32, inst[25:20] when XLEN=64.
  - CSR = zero-extended inst[19:15].
  - none: imm=0, err=1. err=0 for all other selects.
- Immediate generation is combinational on the input side. The result is captured into the output register. Latency from handshake to out_valid is exactly 1 cycle.
- Handshake:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
  - out_imm/out_tag/out_err must hold stable while out_valid && !out_ready.
- in_ready is a registered signal: in_ready = !skid_valid. It must not depend combinationally on out_ready.
- Skid buffer, one entry:
  - If an input transfers while the output register holds data that is not accepted this cycle, the new entry goes to the skid register (skid_valid=1).
  - When the output is accepted, the skid entry moves to the output register (out_valid stays 1). in_ready rises the next cycle.
  - Otherwise an input transfer loads the output register directly.
- Simultaneous input and output transfer with the skid empty: the output register loads the new entry. out_valid stays 1, giving 1 entry per cycle throughput.
- flush has priority over in/out transfers in the same cycle. Next cycle: out_valid=0, skid_valid=0, in_ready=1. An input offered in the flush cycle is discarded. Data registers need not clear.
- Ordering: entries leave in the order accepted. No loss and no duplication.
- Maximum occupancy is 2 (output register plus skid). With the skid full, in_ready=0 and in_valid is ignored.

Test Plan:
- XLEN=32, I: in_inst=0xFE010113, sel=4, out_ready=1 -> next cycle out_valid=1, out_imm=0xFFFFFFE0, err=0.
- B and U, back-to-back with out_ready=1: 0xFE000EE3 sel=1 then 0x123450B7 sel=2 -> out_imm 0xFFFFFFFC then 0x12345000 on consecutive cycles, in_ready held 1.
- XLEN=64, I_star and U: 0x03F09093 sel=5 -> out_imm=63. Then 0x800000B7 sel=2 -> out_imm=0xFFFFFFFF80000000.
- Backpressure: out_ready=0, send 3 entries (CSR inst[19:15]=0x15 tag 1, sel=7 tag 2, I tag 3) -> first two accepted, in_ready=0 on the 3rd. Outputs stable. Raise out_ready -> tags 1,2,3 emerge in order with imm 21 and err 0, then imm 0 and err 1, then the I result.
- Flush with the skid full and in_valid=1 in the same cycle -> next cycle out_valid=0, in_ready=1, and no flushed tag ever appears on the output.
- Assert rst_n=0 asynchronously mid-transfer with the skid full -> outputs go to reset values immediately, before the next clk edge. After release, the first accepted entry appears 1 cycle later.

Source files
------------

// File: rtl/imm_gen_pipe.sv
// rtl/imm_gen_pipe.sv - registered immediate generator with 1-entry skid buffer
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [2:0]       in_sel,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_err
);

  localparam logic [2:0] SEL_S    = 3'd0;
  localparam logic [2:0] SEL_B    = 3'd1;
  localparam logic [2:0] SEL_U    = 3'd2;
  localparam logic [2:0] SEL_J    = 3'd3;
  localparam logic [2:0] SEL_I    = 3'd4;
  localparam logic [2:0] SEL_ISH  = 3'd5;
  localparam logic [2:0] SEL_CSR  = 3'd6;

  logic             skid_valid;
  logic [XLEN-1:0]  skid_imm;
  logic [TAG_W-1:0] skid_tag;
  logic             skid_err;

  logic [31:0]      imm32;
  logic [XLEN-1:0]  new_imm;
  logic             new_err;
  logic             in_fire;
  logic             out_free;

  // Opcode bits never contribute to any immediate.
  logic unused_opcode;
  assign unused_opcode = ^in_inst[6:0];

  // Build every format as a 32-bit value whose bit 31 already carries the
  // correct extension bit, so a single signed widening covers RV64.
  always_comb begin
    imm32   = 32'd0;
    new_err = 1'b0;
    case (in_sel)
      SEL_S:   imm32 = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
      SEL_B:   imm32 = {{20{in_inst[31]}}, in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
      SEL_U:   imm32 = {in_inst[31:12], 12'd0};
      SEL_J:   imm32 = {{12{in_inst[31]}}, in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};
      SEL_I:   imm32 = {{20{in_inst[31]}}, in_inst[31:20]};
      SEL_ISH: imm32 = (XLEN == 64) ? {26'd0, in_inst[25:20]} : {27'd0, in_inst[24:20]};
      SEL_CSR: imm32 = {27'd0, in_inst[19:15]};
      default: new_err = 1'b1;
    endcase
    new_imm = XLEN'($signed(imm32));
  end

  // in_ready comes straight from a flop so it never sees out_ready.
  assign in_ready = !skid_valid;
  assign in_fire  = in_valid && in_ready;
  assign out_free = !out_valid || out_ready;

  // Output register and skid buffer: skid drains first, then direct loads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_imm    <= '0;
      out_tag    <= '0;
      out_err    <= 1'b0;
      skid_valid <= 1'b0;
      skid_imm   <= '0;
      skid_tag   <= '0;
      skid_err   <= 1'b0;
    end else if (flush) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else if (out_free) begin
      if (skid_valid) begin
        out_valid  <= 1'b1;
        out_imm    <= skid_imm;
        out_tag    <= skid_tag;
        out_err    <= skid_err;
        skid_valid <= 1'b0;
      end else if (in_fire) begin
        out_valid <= 1'b1;
        out_imm   <= new_imm;
        out_tag   <= in_tag;
        out_err   <= new_err;
      end else begin
        out_valid <= 1'b0;
      end
    end else if (in_fire) begin
      skid_valid <= 1'b1;
      skid_imm   <= new_imm;
      skid_tag   <= in_tag;
      skid_err   <= new_err;
    end
  end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb/tb_imm_gen_pipe.sv - randomized and directed bench for imm_gen_pipe (RV32 and RV64 instances)
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, out_ready;
  logic [31:0] in_inst;
  logic [2:0]  in_sel;
  logic [4:0]  in_tag;

  logic        in_ready32, out_valid32, out_err32;
  logic [31:0] out_imm32;
  logic [4:0]  out_tag32;
  logic        in_ready64, out_valid64, out_err64;
  logic [63:0] out_imm64;
  logic [4:0]  out_tag64;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] inst;
    logic [2:0]  sel;
    logic [4:0]  tag;
  } entry_t;
  entry_t q[$];

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .TAG_W(5)) dut32 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready32),
    .in_inst(in_inst), .in_sel(in_sel), .in_tag(in_tag), .out_valid(out_valid32),
    .out_ready(out_ready), .out_imm(out_imm32), .out_tag(out_tag32), .out_err(out_err32)
  );

  imm_gen_pipe #(.XLEN(64), .TAG_W(5)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready64),
    .in_inst(in_inst), .in_sel(in_sel), .in_tag(in_tag), .out_valid(out_valid64),
    .out_ready(out_ready), .out_imm(out_imm64), .out_tag(out_tag64), .out_err(out_err64)
  );

  // Reference immediate as a signed integer value, truncated for RV32.
  function automatic logic [63:0] ref_imm(input logic [31:0] inst, input logic [2:0] sel, input int xlen);
    longint v;
    logic [63:0] r;
    case (sel)
      3'd0: v = $signed({inst[31:25], inst[11:7]});
      3'd1: v = $signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0});
      3'd2: v = $signed({inst[31:12], 12'd0});
      3'd3: v = $signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0});
      3'd4: v = $signed(inst[31:20]);
      3'd5: v = (xlen == 64) ? longint'(inst[25:20]) : longint'(inst[24:20]);
      3'd6: v = longint'(inst[19:15]);
      default: v = 0;
    endcase
    r = v;
    if (xlen == 32) r[63:32] = 32'd0;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] i, input logic [2:0] s, input logic [4:0] t);
    in_valid = v;
    in_inst  = i;
    in_sel   = s;
    in_tag   = t;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
    drive(1'b0, 32'd0, 3'd0, 5'd0);
    tick(); tick();
    checks++;
    if (out_valid32 !== 1'b0 || out_valid64 !== 1'b0 || in_ready32 !== 1'b1 || in_ready64 !== 1'b1) begin
      failures++;
      $display("FAIL reset_hs got v=%b/%b r=%b/%b exp v=0 r=1", out_valid32, out_valid64, in_ready32, in_ready64);
    end
    checks++;
    if (out_imm32 !== 32'd0 || out_imm64 !== 64'd0 || out_tag32 !== 5'd0 || out_err32 !== 1'b0 || out_err64 !== 1'b0) begin
      failures++;
      $display("FAIL reset_data got imm=%h/%h tag=%h err=%b exp zeros", out_imm32, out_imm64, out_tag32, out_err32);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (out_valid32 !== 1'b0 || in_ready32 !== 1'b1) begin
      failures++;
      $display("FAIL reset_release got v=%b r=%b exp v=0 r=1", out_valid32, in_ready32);
    end
  endtask

  task automatic test_i_format();
    out_ready = 1'b1;
    drive(1'b1, 32'hFE010113, 3'd4, 5'd3);
    tick();
    drive(1'b0, 32'd0, 3'd0, 5'd0);
    checks++;
    if (out_valid32 !== 1'b1 || out_imm32 !== 32'hFFFFFFE0 || out_err32 !== 1'b0 || out_tag32 !== 5'd3) begin
      failures++;
      $display("FAIL i32 got v=%b imm=%h err=%b tag=%0d exp v=1 imm=ffffffe0 err=0 tag=3", out_valid32, out_imm32, out_err32, out_tag32);
    end
    checks++;
    if (out_valid64 !== 1'b1 || out_imm64 !== 64'hFFFFFFFFFFFFFFE0) begin
      failures++;
      $display("FAIL i64 got v=%b imm=%h exp v=1 imm=ffffffffffffffe0", out_valid64, out_imm64);
    end
    tick();
    checks++;
    if (out_valid32 !== 1'b0) begin
      failures++;
      $display("FAIL i_drain got v=%b exp 0", out_valid32);
    end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    drive(1'b1, 32'hFE000EE3, 3'd1, 5'd4);
    tick();
    checks++;
    if (out_imm32 !== 32'hFFFFFFFC || out_imm64 !== 64'hFFFFFFFFFFFFFFFC || out_valid32 !== 1'b1 || in_ready32 !== 1'b1) begin
      failures++;
      $display("FAIL b2b_b got imm=%h/%h v=%b r=%b exp fffffffc v=1 r=1", out_imm32, out_imm64, out_valid32, in_ready32);
    end
    drive(1'b1, 32'h123450B7, 3'd2, 5'd5);
    tick();
    drive(1'b0, 32'd0, 3'd0, 5'd0);
    checks++;
    if (out_imm32 !== 32'h12345000 || out_imm64 !== 64'h0000000012345000 || out_tag32 !== 5'd5 || out_valid32 !== 1'b1 || in_ready32 !== 1'b1) begin
      failures++;
      $display("FAIL b2b_u got imm=%h/%h tag=%0d v=%b r=%b exp 12345000 tag=5 v=1 r=1", out_imm32, out_imm64, out_tag32, out_valid32, in_ready32);
    end
    tick();
  endtask

  task automatic test_rv64_formats();
    out_ready = 1'b1;
    drive(1'b1, 32'h03F09093, 3'd5, 5'd6);
    tick();
    checks++;
    if (out_imm64 !== 64'd63 || out_imm32 !== 32'd31) begin
      failures++;
      $display("FAIL shamt got imm64=%0d imm32=%0d exp 63 and 31", out_imm64, out_imm32);
    end
    drive(1'b1, 32'h800000B7, 3'd2, 5'd7);
    tick();
    drive(1'b0, 32'd0, 3'd0, 5'd0);
    checks++;
    if (out_imm64 !== 64'hFFFFFFFF80000000 || out_imm32 !== 32'h80000000) begin
      failures++;
      $display("FAIL u64 got imm64=%h imm32=%h exp ffffffff80000000 and 80000000", out_imm64, out_imm32);
    end
    tick();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    drive(1'b1, 32'h000A8073, 3'd6, 5'd1);
    tick();
    drive(1'b1, 32'hDEADBEEF, 3'd7, 5'd2);
    tick();
    checks++;
    if (in_ready32 !== 1'b0 || in_ready64 !== 1'b0 || out_tag32 !== 5'd1 || out_imm32 !== 32'd21) begin
      failures++;
      $display("FAIL bp_full got r=%b/%b tag=%0d imm=%0d exp r=0 tag=1 imm=21", in_ready32, in_ready64, out_tag32, out_imm32);
    end
    drive(1'b1, 32'h00500093, 3'd4, 5'd3);
    tick();
    checks++;
    if (in_ready32 !== 1'b0 || out_valid32 !== 1'b1 || out_tag32 !== 5'd1 || out_imm32 !== 32'd21 || out_err32 !== 1'b0) begin
      failures++;
      $display("FAIL bp_stable got r=%b v=%b tag=%0d imm=%0d err=%b exp r=0 v=1 tag=1 imm=21 err=0", in_ready32, out_valid32, out_tag32, out_imm32, out_err32);
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if (out_valid32 !== 1'b1 || out_tag32 !== 5'd2 || out_imm32 !== 32'd0 || out_err32 !== 1'b1 || out_err64 !== 1'b1 || in_ready32 !== 1'b1) begin
      failures++;
      $display("FAIL bp_second got v=%b tag=%0d imm=%0d err=%b r=%b exp v=1 tag=2 imm=0 err=1 r=1", out_valid32, out_tag32, out_imm32, out_err32, in_ready32);
    end
    tick();
    drive(1'b0, 32'd0, 3'd0, 5'd0);
    checks++;
    if (out_valid64 !== 1'b1 || out_tag64 !== 5'd3 || out_imm64 !== 64'd5 || out_err64 !== 1'b0) begin
      failures++;
      $display("FAIL bp_third got v=%b tag=%0d imm=%0d err=%b exp v=1 tag=3 imm=5 err=0", out_valid64, out_tag64, out_imm64, out_err64);
    end
    tick();
    checks++;
    if (out_valid32 !== 1'b0 || out_valid64 !== 1'b0) begin
      failures++;
      $display("FAIL bp_drain got v=%b/%b exp 0", out_valid32, out_valid64);
    end
  endtask

  task automatic test_flush();
    int seen_bad = 0;
    out_ready = 1'b0;
    drive(1'b1, 32'h00100093, 3'd4, 5'd10);
    tick();
    drive(1'b1, 32'h00200093, 3'd4, 5'd11);
    tick();
    drive(1'b1, 32'h00300093, 3'd4, 5'd12);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(1'b0, 32'd0, 3'd0, 5'd0);
    checks++;
    if (out_valid32 !== 1'b0 || out_valid64 !== 1'b0 || in_ready32 !== 1'b1 || in_ready64 !== 1'b1) begin
      failures++;
      $display("FAIL flush_state got v=%b/%b r=%b/%b exp v=0 r=1", out_valid32, out_valid64, in_ready32, in_ready64);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (out_valid32 || out_valid64) seen_bad++;
    end
    checks++;
    if (seen_bad != 0) begin
      failures++;
      $display("FAIL flush_leak got %0d cycles with flushed output exp 0", seen_bad);
    end
    drive(1'b1, 32'h00D00093, 3'd4, 5'd13);
    tick();
    drive(1'b0, 32'd0, 3'd0, 5'd0);
    checks++;
    if (out_valid32 !== 1'b1 || out_tag32 !== 5'd13 || out_imm32 !== 32'd13) begin
      failures++;
      $display("FAIL flush_after got v=%b tag=%0d imm=%0d exp v=1 tag=13 imm=13", out_valid32, out_tag32, out_imm32);
    end
    tick();
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    drive(1'b1, 32'hFFF00093, 3'd4, 5'd20);
    tick();
    drive(1'b1, 32'h00100093, 3'd4, 5'd21);
    tick();
    drive(1'b1, 32'h01600093, 3'd4, 5'd22);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid32 !== 1'b0 || out_valid64 !== 1'b0 || in_ready32 !== 1'b1 || out_tag32 !== 5'd0 || out_imm64 !== 64'd0 || out_err32 !== 1'b0) begin
      failures++;
      $display("FAIL areset_now got v=%b/%b r=%b tag=%0d imm=%h err=%b exp reset values", out_valid32, out_valid64, in_ready32, out_tag32, out_imm64, out_err32);
    end
    tick();
    checks++;
    if (out_valid32 !== 1'b0 || out_valid64 !== 1'b0 || out_tag64 !== 5'd0) begin
      failures++;
      $display("FAIL areset_hold got v=%b/%b tag=%0d exp v=0 tag=0", out_valid32, out_valid64, out_tag64);
    end
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    drive(1'b0, 32'd0, 3'd0, 5'd0);
    checks++;
    if (out_valid32 !== 1'b1 || out_tag32 !== 5'd22 || out_imm32 !== 32'd22 || out_imm64 !== 64'd22) begin
      failures++;
      $display("FAIL areset_first got v=%b tag=%0d imm=%0d/%0d exp v=1 tag=22 imm=22", out_valid32, out_tag32, out_imm32, out_imm64);
    end
    tick();
  endtask

  task automatic test_random();
    logic [63:0] e32, e64;
    logic        do_flush, v, rdy;
    out_ready = 1'b1;
    flush = 1'b0;
    drive(1'b0, 32'd0, 3'd0, 5'd0);
    tick(); tick();
    q.delete();
    for (int cyc = 0; cyc < 600; cyc++) begin
      checks++;
      if (out_valid32 !== (q.size() > 0) || out_valid64 !== (q.size() > 0) ||
          in_ready32 !== (q.size() < 2) || in_ready64 !== (q.size() < 2)) begin
        failures++;
        $display("FAIL rnd_hs cyc=%0d got v=%b/%b r=%b/%b exp occupancy=%0d", cyc, out_valid32, out_valid64, in_ready32, in_ready64, q.size());
      end
      if (q.size() > 0) begin
        e32 = ref_imm(q[0].inst, q[0].sel, 32);
        e64 = ref_imm(q[0].inst, q[0].sel, 64);
        checks++;
        if (out_tag32 !== q[0].tag || out_tag64 !== q[0].tag || out_imm32 !== e32[31:0] || out_imm64 !== e64 ||
            out_err32 !== (q[0].sel == 3'd7) || out_err64 !== (q[0].sel == 3'd7)) begin
          failures++;
          $display("FAIL rnd_data cyc=%0d got tag=%0d/%0d imm=%h/%h err=%b/%b exp tag=%0d imm=%h/%h sel=%0d",
                   cyc, out_tag32, out_tag64, out_imm32, out_imm64, out_err32, out_err64, q[0].tag, e32[31:0], e64, q[0].sel);
        end
      end
      do_flush = ($urandom_range(0, 24) == 0);
      v   = ($urandom_range(0, 3) != 0);
      rdy = ($urandom_range(0, 2) != 0);
      flush = do_flush;
      out_ready = rdy;
      drive(v, $urandom, 3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)));
      if (do_flush) begin
        q.delete();
      end else begin
        logic can_take;
        can_take = (q.size() < 2);
        if (q.size() > 0 && rdy) void'(q.pop_front());
        if (v && can_take) q.push_back('{inst: in_inst, sel: in_sel, tag: in_tag});
      end
      tick();
    end
    flush = 1'b0;
    drive(1'b0, 32'd0, 3'd0, 5'd0);
  endtask

  initial begin
    test_reset();
    test_i_format();
    test_back_to_back();
    test_rv64_formats();
    test_backpressure();
    test_flush();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
